floo_serial_link_vc_mux: RTL and testbench

//  Next-generation link-side channel mux for the floo serial link. Merges NumVc flit streams
//  (narrow req, narrow rsp, wide, ...) onto one physical flit stream, tagged with a VC index.

---
 rtl/floo_serial_link_vc_pkg.sv | 11 +
 rtl/floo_serial_link_credit_cnt.sv | 53 +++++
 rtl/floo_serial_link_vc_mux.sv | 137 +++++++++++++
 tb/tb_floo_serial_link_vc_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/floo_serial_link_vc_pkg.sv
// Shared constants and helpers for the floo serial link VC mux and its credit counters.
package floo_serial_link_vc_pkg;

  localparam int unsigned MaxNumVc          = 8;
  localparam int unsigned DefaultNumCredits = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/floo_serial_link_credit_cnt.sv
// Per-VC credit counter mirroring the free space of the remote receive buffer.
module floo_serial_link_credit_cnt #(
  parameter int unsigned NumCredits = 8,
  parameter int unsigned CntWidth   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                take_i,
  input  logic                give_i,
  output logic [CntWidth-1:0] count_o,
  output logic                nonzero_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] Full = CntWidth'(NumCredits);

  logic [CntWidth-1:0] count_d, count_q;
  logic                err_d, err_q;

  // A simultaneous take and give cancel out, so a full counter never flags an error then.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (take_i && !give_i) begin
      count_d = count_q - CntWidth'(1);
    end else if (give_i && !take_i) begin
      if (count_q == Full) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= Full;
      err_q   <= 1'b0;
    end else if (flush_i) begin
      count_q <= Full;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);
  assign err_o     = err_q;

endmodule

// File: rtl/floo_serial_link_vc_mux.sv
// Credit-gated round-robin mux of NumVc flit streams onto one registered link stream.
// Optional per-VC sent-flit counters are built when SERIAL_LINK_VC_MUX_PERF_EN is defined.
module floo_serial_link_vc_mux
  import floo_serial_link_vc_pkg::*;
#(
  parameter  int unsigned NumVc      = 3,
  parameter  int unsigned FlitWidth  = 64,
  parameter  int unsigned NumCredits = DefaultNumCredits,
  localparam int unsigned CntWidth   = cnt_width(NumCredits),
  localparam int unsigned VcW        = $clog2(NumVc)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NumVc-1:0]                   valid_i,
  output logic [NumVc-1:0]                   ready_o,
  input  logic [NumVc-1:0][FlitWidth-1:0]    data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [FlitWidth-1:0]               data_o,
  output logic [VcW-1:0]                     vc_o,
  input  logic [NumVc-1:0]                   credit_i,
  output logic [NumVc-1:0][CntWidth-1:0]     credits_o,
  output logic                               credit_err_o,
  output logic [NumVc-1:0][31:0]             sent_cnt_o
);

  if (NumVc < 2 || NumVc > MaxNumVc) begin : gen_bad_num_vc
    $error("floo_serial_link_vc_mux: NumVc must be in 2..8");
  end
  if (NumCredits < 1 || NumCredits > 255) begin : gen_bad_num_credits
    $error("floo_serial_link_vc_mux: NumCredits must be in 1..255");
  end

  logic [NumVc-1:0]     nonzero;
  logic [NumVc-1:0]     err_vec;
  logic [NumVc-1:0]     eligible;
  logic [NumVc-1:0]     grant_oh;
  logic [VcW-1:0]       gnt_idx;
  logic [VcW-1:0]       rr_next;
  logic                 found;
  logic                 load;
  logic                 grant_valid;

  logic                 valid_q;
  logic [FlitWidth-1:0] data_q;
  logic [VcW-1:0]       vc_q;
  logic [VcW-1:0]       rr_q;

  for (genvar v = 0; v < NumVc; v++) begin : gen_credit
    floo_serial_link_credit_cnt #(
      .NumCredits (NumCredits),
      .CntWidth   (CntWidth)
    ) i_credit_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .take_i    (ready_o[v]),
      .give_i    (credit_i[v]),
      .count_o   (credits_o[v]),
      .nonzero_o (nonzero[v]),
      .err_o     (err_vec[v])
    );
  end

  assign eligible     = valid_i & nonzero;
  assign load         = !valid_q || ready_i;
  assign credit_err_o = |err_vec;

  // Scan starting at the rr pointer so a zero-credit VC is simply passed over.
  always_comb begin
    grant_oh = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NumVc; i++) begin
      automatic int unsigned idx = 32'(rr_q) + i;
      if (idx >= NumVc) idx = idx - NumVc;
      if (!found && eligible[idx]) begin
        grant_oh[idx] = 1'b1;
        gnt_idx       = VcW'(idx);
        found         = 1'b1;
      end
    end
  end

  assign grant_valid = found && load && !flush_i;
  assign ready_o     = grant_valid ? grant_oh : '0;
  assign rr_next     = (gnt_idx == VcW'(NumVc - 1)) ? '0 : gnt_idx + VcW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      vc_q    <= '0;
      rr_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      vc_q    <= '0;
      rr_q    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        valid_q <= 1'b1;
        data_q  <= data_i[gnt_idx];
        vc_q    <= gnt_idx;
        rr_q    <= rr_next;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign vc_o    = vc_q;

`ifdef SERIAL_LINK_VC_MUX_PERF_EN
  logic [NumVc-1:0][31:0] sent_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_cnt_q <= '0;
    end else if (flush_i) begin
      sent_cnt_q <= '0;
    end else begin
      for (int unsigned v = 0; v < NumVc; v++) begin
        if (ready_o[v]) sent_cnt_q[v] <= sent_cnt_q[v] + 32'd1;
      end
    end
  end

  assign sent_cnt_o = sent_cnt_q;
`else
  assign sent_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_serial_link_vc_mux.sv
// Directed bench for floo_serial_link_vc_mux with NumVc=3, FlitWidth=64, NumCredits=4.
module tb_floo_serial_link_vc_mux;

`ifdef SERIAL_LINK_VC_MUX_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic             clk;
  logic             rstN;
  logic             flush;
  logic [2:0]       validIn;
  logic [2:0]       readyOut;
  logic [2:0][63:0] dataIn;
  logic             validOut;
  logic             readyIn;
  logic [63:0]      dataOut;
  logic [1:0]       vcOut;
  logic [2:0]       creditIn;
  logic [2:0][2:0]  credits;
  logic             creditErr;
  logic [2:0][31:0] sentCnt;

  int assertCount = 0;
  int failCount   = 0;
  int grantCount;

  floo_serial_link_vc_mux #(
    .NumVc      (3),
    .FlitWidth  (64),
    .NumCredits (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .flush_i      (flush),
    .valid_i      (validIn),
    .ready_o      (readyOut),
    .data_i       (dataIn),
    .valid_o      (validOut),
    .ready_i      (readyIn),
    .data_o       (dataOut),
    .vc_o         (vcOut),
    .credit_i     (creditIn),
    .credits_o    (credits),
    .credit_err_o (creditErr),
    .sent_cnt_o   (sentCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [2:0] cr, input logic rdy, input logic fl);
    validIn  = v;
    creditIn = cr;
    readyIn  = rdy;
    flush    = fl;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doFlush();
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
  endtask

  initial begin
    rstN     = 1'b0;
    flush    = 1'b0;
    validIn  = '0;
    creditIn = '0;
    readyIn  = 1'b0;
    dataIn[0] = 64'h1000;
    dataIn[1] = 64'h1001;
    dataIn[2] = 64'h1002;
    #12;
    checkOutput("rst_valid", validOut, 0);
    checkOutput("rst_data", dataOut, 0);
    checkOutput("rst_vc", vcOut, 0);
    checkOutput("rst_cred0", credits[0], 4);
    checkOutput("rst_cred2", credits[2], 4);
    checkOutput("rst_err", creditErr, 0);
    checkOutput("rst_sent1", sentCnt[1], 0);

    $display("[TB] Test 1: round robin over all VCs");
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
    rstN = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t1_ready%0d", k), readyOut, 64'(3'b001 << (k % 3)));
      stepCycle();
      checkOutput($sformatf("t1_valid%0d", k), validOut, 1);
      checkOutput($sformatf("t1_vc%0d", k), vcOut, 64'(k % 3));
      checkOutput($sformatf("t1_data%0d", k), dataOut, 64'h1000 + 64'(k % 3));
    end
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
    checkOutput("t1_cred0", credits[0], 2);
    checkOutput("t1_cred1", credits[1], 3);
    checkOutput("t1_cred2", credits[2], 3);
    checkOutput("t1_sent0", sentCnt[0], PerfEn ? 2 : 0);
    stepCycle();
    checkOutput("t1_idle_valid", validOut, 0);

    $display("[TB] Test 2: single VC runs out of credits");
    doFlush();
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0);
    grantCount = 0;
    for (int k = 0; k < 8; k++) begin
      if (readyOut[1]) grantCount++;
      stepCycle();
    end
    checkOutput("t2_grants", grantCount, 4);
    checkOutput("t2_ready_starved", readyOut, 0);
    checkOutput("t2_cred1_zero", credits[1], 0);
    checkOutput("t2_valid_drained", validOut, 0);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    checkOutput("t2_ready_at_credit", readyOut, 0);
    stepCycle();
    checkOutput("t2_cred1_one", credits[1], 1);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0);
    grantCount = 0;
    for (int k = 0; k < 6; k++) begin
      if (readyOut[1]) grantCount++;
      stepCycle();
    end
    checkOutput("t2_extra_grants", grantCount, 1);
    checkOutput("t2_cred1_end", credits[1], 0);

    $display("[TB] Test 3: output stage holds under back-pressure");
    doFlush();
    dataIn[0] = 64'hDEAD;
    applyStimulus(3'b001, 3'b000, 1'b0, 1'b0);
    checkOutput("t3_first_ready", readyOut, 3'b001);
    stepCycle();
    dataIn[0] = 64'hBEEF;
    #1;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t3_hold_ready%0d", k), readyOut, 0);
      checkOutput($sformatf("t3_hold_valid%0d", k), validOut, 1);
      checkOutput($sformatf("t3_hold_data%0d", k), dataOut, 64'hDEAD);
      checkOutput($sformatf("t3_hold_vc%0d", k), vcOut, 0);
      stepCycle();
    end
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0);
    checkOutput("t3_release_ready", readyOut, 3'b001);
    stepCycle();
    checkOutput("t3_next_data", dataOut, 64'hBEEF);
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
    checkOutput("t3_cred0", credits[0], 2);

    $display("[TB] Test 4: simultaneous grant and credit return, overflow");
    doFlush();
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("t4_cred2_two", credits[2], 2);
    applyStimulus(3'b100, 3'b100, 1'b1, 1'b0);
    checkOutput("t4_ready2", readyOut, 3'b100);
    stepCycle();
    checkOutput("t4_cred2_same", credits[2], 2);
    checkOutput("t4_err_none", creditErr, 0);
    applyStimulus(3'b000, 3'b001, 1'b1, 1'b0);
    stepCycle();
    checkOutput("t4_cred0_full", credits[0], 4);
    checkOutput("t4_err_set", creditErr, 1);
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("t4_err_sticky", creditErr, 1);

    $display("[TB] Test 5: flush with a flit in the output stage");
    applyStimulus(3'b010, 3'b100, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("t5_pre_cred0", credits[0], 1);
    checkOutput("t5_pre_cred1", credits[1], 0);
    checkOutput("t5_pre_cred2", credits[2], 3);
    checkOutput("t5_pre_valid", validOut, 1);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b1);
    checkOutput("t5_flush_ready", readyOut, 0);
    stepCycle();
    checkOutput("t5_valid", validOut, 0);
    checkOutput("t5_data", dataOut, 0);
    checkOutput("t5_cred0", credits[0], 4);
    checkOutput("t5_cred1", credits[1], 4);
    checkOutput("t5_cred2", credits[2], 4);
    checkOutput("t5_err", creditErr, 0);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
    checkOutput("t5_first_grant", readyOut, 3'b001);

    $display("[TB] Test 6: sent-flit counters");
    doFlush();
    checkOutput("t6_sent1_clear", sentCnt[1], 0);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) stepCycle();
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
    checkOutput("t6_sent1", sentCnt[1], PerfEn ? 5 : 0);
    checkOutput("t6_sent0", sentCnt[0], 0);
    checkOutput("t6_cred1", credits[1], 4);

    $display("[TB] Reset during a transfer");
    applyStimulus(3'b001, 3'b000, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rst_mid_pre_valid", validOut, 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_valid", validOut, 0);
    checkOutput("rst_mid_cred0", credits[0], 4);
    #1;
    rstN = 1'b1;
    #1;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
